// File: rtl/uart_mem_loader.sv
// UART image loader: receives an 8N1 byte stream (sync byte, word count, data)
// and writes the assembled little-endian 32-bit words into memory.
module uart_mem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  loading,
  output logic                  done,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {WAIT_SYNC, GET_COUNT, GET_DATA, WRITE} ld_state_t;

  logic            rx_s1, rx_s2;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   clk_cnt, clk_cnt_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      rx_byte, rx_byte_n;
  logic            byte_valid, byte_err, false_start;

  ld_state_t             ld_state, ld_next;
  logic [7:0]            word_cnt, word_cnt_n;
  logic [1:0]            byte_idx, byte_idx_n;
  logic [31:0]           word_q, word_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic                  loading_n, done_n, frame_err_n;

  // Receiver state; the synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      rx_byte  <= rx_byte_n;
    end
  end

  always_comb begin
    rx_next     = rx_state;
    clk_cnt_n   = clk_cnt + CW'(1);
    bit_cnt_n   = bit_cnt;
    rx_byte_n   = rx_byte;
    byte_valid  = 1'b0;
    byte_err    = 1'b0;
    false_start = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s2) rx_next = RX_START;
      end
      RX_START: begin
        // Mid-bit check; every later sample lands one full bit after this point
        if (clk_cnt == HALF_END) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          if (rx_s2) begin
            false_start = 1'b1;
            rx_next     = RX_IDLE;
          end else begin
            rx_next = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n = '0;
          rx_byte_n = {rx_s2, rx_byte[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_END) begin
          clk_cnt_n  = '0;
          byte_valid = rx_s2;
          byte_err   = !rx_s2;
          rx_next    = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state  <= WAIT_SYNC;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_q    <= '0;
      mem_addr  <= '0;
      loading   <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ld_state  <= ld_next;
      word_cnt  <= word_cnt_n;
      byte_idx  <= byte_idx_n;
      word_q    <= word_n;
      mem_addr  <= addr_n;
      loading   <= loading_n;
      done      <= done_n;
      frame_err <= frame_err_n;
    end
  end

  // Any line error inside a transaction abandons it; completed words stay written
  always_comb begin
    ld_next     = ld_state;
    word_cnt_n  = word_cnt;
    byte_idx_n  = byte_idx;
    word_n      = word_q;
    addr_n      = mem_addr;
    loading_n   = loading;
    done_n      = 1'b0;
    frame_err_n = 1'b0;
    case (ld_state)
      WAIT_SYNC: begin
        if (byte_valid && rx_byte == SYNC_BYTE) ld_next = GET_COUNT;
      end
      GET_COUNT: begin
        if (byte_err || false_start) begin
          frame_err_n = 1'b1;
          ld_next     = WAIT_SYNC;
        end else if (byte_valid) begin
          if (rx_byte == 8'd0) begin
            done_n  = 1'b1;
            ld_next = WAIT_SYNC;
          end else begin
            loading_n  = 1'b1;
            word_cnt_n = rx_byte;
            addr_n     = '0;
            byte_idx_n = '0;
            ld_next    = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (byte_err || false_start) begin
          frame_err_n = 1'b1;
          loading_n   = 1'b0;
          ld_next     = WAIT_SYNC;
        end else if (byte_valid) begin
          word_n[{byte_idx, 3'b000} +: 8] = rx_byte;
          byte_idx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) ld_next = WRITE;
        end
      end
      WRITE: begin
        addr_n     = mem_addr + ADDR_WIDTH'(1);
        word_cnt_n = word_cnt - 8'd1;
        byte_idx_n = '0;
        if (word_cnt == 8'd1) begin
          done_n    = 1'b1;
          loading_n = 1'b0;
          ld_next   = WAIT_SYNC;
        end else begin
          ld_next = GET_DATA;
        end
      end
      default: ld_next = WAIT_SYNC;
    endcase
  end

  assign mem_we    = (ld_state == WRITE);
  assign mem_wdata = word_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: a byte-level model of the load protocol
// predicts writes/done/frame_err events, plus literal checks per scenario.
module tb_uart_mem_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        loading, done, frame_err;

  int total = 0;
  int bad = 0;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .loading(loading),
    .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  localparam int EV_WRITE = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_FERR  = 2;

  ev_t exp_q[$];

  int         m_mode = 0;
  int         m_left = 0;
  logic [7:0] m_addr = 8'd0;
  logic       m_loading = 1'b0;
  logic [7:0] m_bytes[$];

  int          n_writes, n_dones, n_ferrs, cycle;
  int          last_we_cycle, last_done_cycle;
  logic [7:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  logic        prev_loading, done_prev_loading, loading_seen;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic void push_ev(input int kind, input logic [7:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Protocol interpretation of one received byte
  function automatic void model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      if (m_mode != 0) push_ev(EV_FERR, 8'd0, 32'd0);
      m_mode = 0;
      m_loading = 1'b0;
      m_bytes.delete();
      return;
    end
    if (m_mode == 0) begin
      if (b == 8'hA5) m_mode = 1;
    end else if (m_mode == 1) begin
      if (b == 8'd0) begin
        push_ev(EV_DONE, 8'd0, 32'd0);
        m_mode = 0;
      end else begin
        m_left = int'(b);
        m_addr = 8'd0;
        m_loading = 1'b1;
        m_bytes.delete();
        m_mode = 2;
      end
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        push_ev(EV_WRITE, m_addr, {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        m_bytes.delete();
        m_addr = m_addr + 8'd1;
        m_left = m_left - 1;
        if (m_left == 0) begin
          push_ev(EV_DONE, 8'd0, 32'd0);
          m_loading = 1'b0;
          m_mode = 0;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_left = 0;
    m_addr = 8'd0;
    m_loading = 1'b0;
    m_bytes.delete();
  endfunction

  // Sends one 8N1 frame followed by two idle bit times, then checks settled state
  task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
    model_byte(b, stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("loading_after_byte", {31'd0, loading}, {31'd0, m_loading});
    checkOutput("addr_after_byte", {24'd0, mem_addr}, {24'd0, m_addr});
  endtask

  task automatic clear_stats();
    n_writes = 0;
    n_dones = 0;
    n_ferrs = 0;
    loading_seen = 1'b0;
  endtask

  // Per-cycle comparison of DUT events against the model's expected queue
  always @(negedge clk) begin
    ev_t e;
    cycle++;
    if (mem_we) begin
      n_writes++;
      last_we_cycle = cycle;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
      checkOutput("we_loading", {31'd0, loading}, 32'd1);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("write_kind", e.kind, EV_WRITE);
        checkOutput("write_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        checkOutput("write_data", mem_wdata, e.data);
      end
    end
    if (done) begin
      n_dones++;
      last_done_cycle = cycle;
      done_prev_loading = prev_loading;
      checkOutput("done_loading", {31'd0, loading}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("done_kind", e.kind, EV_DONE);
      end
    end
    if (frame_err) begin
      n_ferrs++;
      checkOutput("ferr_loading", {31'd0, loading}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame_err", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ferr_kind", e.kind, EV_FERR);
      end
    end
    if (loading) loading_seen = 1'b1;
    prev_loading = loading;
  end

  task automatic check_all_zero(input string name);
    checkOutput({name, "_we"}, {31'd0, mem_we}, 32'd0);
    checkOutput({name, "_addr"}, {24'd0, mem_addr}, 32'd0);
    checkOutput({name, "_wdata"}, mem_wdata, 32'd0);
    checkOutput({name, "_loading"}, {31'd0, loading}, 32'd0);
    checkOutput({name, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({name, "_ferr"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] t1[6];
    logic [7:0] t6[6];
    cycle = 0;
    prev_loading = 1'b0;
    clear_stats();
    t1 = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    t6 = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single word load");
    clear_stats();
    foreach (t1[i]) applyStimulus(t1[i], 1'b1);
    checkOutput("t1_writes", n_writes, 1);
    checkOutput("t1_addr", {24'd0, last_wr_addr}, 32'd0);
    checkOutput("t1_data", last_wr_data, 32'h12345678);
    checkOutput("t1_done_count", n_dones, 1);
    checkOutput("t1_done_latency", last_done_cycle - last_we_cycle, 1);
    checkOutput("t1_loading_fell_with_done", {31'd0, done_prev_loading}, 32'd1);

    $display("[TB] three word load");
    clear_stats();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h03, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(8'(i), 1'b1);
    checkOutput("t2_writes", n_writes, 3);
    checkOutput("t2_last_data", last_wr_data, 32'h0B0A0908);
    checkOutput("t2_addr_after", {24'd0, mem_addr}, 32'd3);

    $display("[TB] no sync then zero count");
    clear_stats();
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t3_writes", n_writes, 0);
    checkOutput("t3_loading_seen", {31'd0, loading_seen}, 32'd0);
    checkOutput("t3_dones", n_dones, 1);

    $display("[TB] stop bit error mid transfer");
    clear_stats();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h02, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(8'h10 + 8'(i), 1'b1);
    applyStimulus(8'h77, 1'b0);
    checkOutput("t4_writes", n_writes, 1);
    checkOutput("t4_data", last_wr_data, 32'h13121110);
    checkOutput("t4_ferrs", n_ferrs, 1);
    checkOutput("t4_dones", n_dones, 0);

    $display("[TB] glitch on idle line");
    clear_stats();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("t5_glitch_ferrs", n_ferrs, 0);
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h01, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(8'hC0 + 8'(i), 1'b1);
    checkOutput("t5_writes", n_writes, 1);
    checkOutput("t5_data", last_wr_data, 32'hC3C2C1C0);
    checkOutput("t5_ferrs", n_ferrs, 0);

    $display("[TB] reset mid transaction");
    clear_stats();
    for (int i = 0; i < 4; i++) applyStimulus(t1[i], 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      uart_rx = t1[4][i];
      repeat (CPB) @(negedge clk);
    end
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    foreach (t6[i]) applyStimulus(t6[i], 1'b1);
    checkOutput("t6_writes", n_writes, 1);
    checkOutput("t6_addr", {24'd0, last_wr_addr}, 32'd0);
    checkOutput("t6_data", last_wr_data, 32'hDEADBEEF);
    checkOutput("t6_dones", n_dones, 1);

    repeat (4 * CPB) @(negedge clk);
    checkOutput("events_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
